nonoverlap_phase_gen: RTL and testbench
=======================================

// Module: nonoverlap_phase_gen
// PURPOSE
//  Generates two non-overlapping clock phases from one master clock, each phase as a
//  complementary EN/nEN pair. PH1/nPH1 and PH2/nPH2 drive the EN/nEN inputs of the
//  latch-based storage in the datapath (master latches on PH1, slave latches on PH2).
//  Phase width and dead time are programmable at run time. Supports free-run and single-step.
// PARAMETERS
//  CNT_W   4   width of HIGH_CYC, DEAD_CYC and the internal phase counter
// PORTS
//  CLK        in   1        master clock; all state changes on its rising edge
//  RST        in   1        reset, asynchronous, active-high
//  RUN        in   1        1 = generate phases continuously
//  STEP       in   1        sampled in IDLE only: run exactly one full PH1/PH2 cycle
//  HIGH_CYC   in   CNT_W    active width of each phase in CLK cycles (0 treated as 1)
//  DEAD_CYC   in   CNT_W    both-phases-low gap in CLK cycles (0 treated as 1)
//  PH1/nPH1   out  1/1      phase 1 enable pair, always complementary
//  PH2/nPH2   out  1/1      phase 2 enable pair, always complementary
//  BUSY       out  1        1 whenever state != IDLE
//  CYCLE_DONE out  1        one-CLK pulse in the last cycle of D2
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, PH1=PH2=0, nPH1=nPH2=1, BUSY=0, CYCLE_DONE=0, counter=0.
//  - FSM: IDLE -> P1 -> D1 -> P2 -> D2 -> (P1 | IDLE).
//    * IDLE->P1 at the first rising edge where RUN=1 or STEP=1 is sampled.
//      PH1 goes high on that same edge; no extra cycle of latency.
//    * P1 lasts max(HIGH_CYC,1) cycles, then D1.
//    * D1 lasts max(DEAD_CYC,1) cycles, then P2.
//    * P2 lasts max(HIGH_CYC,1) cycles, then D2.
//    * D2 lasts max(DEAD_CYC,1) cycles. At its end the FSM goes to P1 if RUN=1 is sampled,
//      otherwise to IDLE. A STEP-started cycle with RUN=0 therefore ends in IDLE.
//  - Period = 2*(max(HIGH_CYC,1)+max(DEAD_CYC,1)) CLK cycles.
//  - Config sampling: HIGH_CYC is loaded into the down-counter on entry to P1/P2; DEAD_CYC is
//    loaded on entry to D1/D2. Changes mid-phase take effect from the next phase. The counter
//    loads value-1 and the phase ends on the cycle where the counter reads 0.
//  - PH1 = (state==P1) and PH2 = (state==P2), each held in a dedicated flop that is updated
//    from the next-state. Decoding outputs combinationally from the state vector is
//    forbidden (it can glitch). nPHx = NOT(PHx flop), so each pair is exactly complementary.
//  - Invariant: PH1 & PH2 is never 1. Every PH1<->PH2 handover has >=1 CLK cycle with both low.
//  - RUN deasserted mid-cycle: the current cycle runs through the end of D2, then IDLE.
//    No phase is ever truncated by RUN.
//  - STEP outside IDLE is ignored. RUN and STEP together in IDLE behave as RUN.
//  - CYCLE_DONE=1 exactly in the final D2 cycle, whether the FSM continues or stops.
//  - RST mid-phase: outputs drop immediately (PHx=0, nPHx=1). After release the FSM waits in
//    IDLE for RUN/STEP.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, P1, D1, P2, D2; 3-bit) and CNT_W default.
//  - Sub-module phase_counter: CNT_W-bit loadable down-counter with async RST, a load
//    input, a load value, and a zero flag. Zero-to-one clamping sits in the parent.
//  - Parent: FSM register, next-state logic, PH1/PH2 output flops, NOT gates for nPH1/nPH2.
// TESTING
//  1. RST=1 with random inputs -> PH1=PH2=0, nPH1=nPH2=1, BUSY=0, CYCLE_DONE=0 throughout reset.
//  2. HIGH_CYC=3, DEAD_CYC=1, RUN=1 held -> PH1 high 3 cycles, 1 low, PH2 high 3 cycles,
//     1 low; period 8; CYCLE_DONE pulses every 8 cycles.
//  3. HIGH_CYC=0, DEAD_CYC=0, RUN=1 -> behaves as 1/1, period 4. PH1&PH2 assertion holds
//     every cycle of every test.
//  4. RUN dropped in the 2nd cycle of P2 (HIGH=3, DEAD=2) -> P2 completes 3 cycles, D2
//     completes 2 cycles with CYCLE_DONE in its last cycle, then IDLE with BUSY=0.
//  5. IDLE, RUN=0, one-cycle STEP pulse (HIGH=2, DEAD=1) -> exactly one PH1 pulse of 2 and one
//     PH2 pulse of 2, then IDLE. A STEP pulse during P2 has no effect.
//  6. RST asserted mid-P1 -> PH1=0, nPH1=1 without waiting for a CLK edge. After release with
//     RUN=1 -> PH1 rises on the first edge.
//  7. HIGH_CYC changed 4->2 during P1 -> current P1 stays 4 cycles; next P2 is 2 cycles.

Source files
------------

// File: rtl/nonoverlap_phase_gen_pkg.sv
// Shared definitions for the non-overlapping two-phase enable generator:
// FSM state encoding and the default counter width.
package nonoverlap_phase_gen_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_D1   = 3'd2,
        ST_P2   = 3'd3,
        ST_D2   = 3'd4
    } state_e;

endpackage

// File: rtl/nonoverlap_phase_gen_if.sv
// Control/config inputs and phase-enable outputs of the phase generator.
// The controller side uses master; the generator itself uses slave.
interface nonoverlap_phase_gen_if
    import nonoverlap_phase_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             run;
    logic             step;
    logic [CNT_W-1:0] high_cyc;
    logic [CNT_W-1:0] dead_cyc;
    logic             ph1;
    logic             nph1;
    logic             ph2;
    logic             nph2;
    logic             busy;
    logic             cycle_done;

    modport master (
        output run, step, high_cyc, dead_cyc,
        input  ph1, nph1, ph2, nph2, busy, cycle_done
    );

    modport slave (
        input  run, step, high_cyc, dead_cyc,
        output ph1, nph1, ph2, nph2, busy, cycle_done
    );

endinterface

// File: rtl/nonoverlap_phase_gen_phase_counter.sv
// Loadable down-counter that times each phase and dead gap; it stops at zero
// and flags it. Any clamping of the load value is done by the parent.
module nonoverlap_phase_gen_phase_counter
    import nonoverlap_phase_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nonoverlap_phase_gen.sv
// Two non-overlapping clock-phase enables (PH1/nPH1, PH2/nPH2) with run-time
// programmable phase width and dead time, in free-run or single-step mode.
module nonoverlap_phase_gen
    import nonoverlap_phase_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    nonoverlap_phase_gen_if.slave        bus_if
);

    state_e           state_q;
    state_e           state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic [CNT_W-1:0] high_m1;
    logic [CNT_W-1:0] dead_m1;
    logic             ph1_d;
    logic             ph1_q;
    logic             ph2_d;
    logic             ph2_q;

    // A programmed width of 0 counts as 1; the counter is loaded with width-1.
    function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign high_m1 = width_m1(bus_if.high_cyc);
    assign dead_m1 = width_m1(bus_if.dead_cyc);

    nonoverlap_phase_gen_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = high_m1;
        unique case (state_q)
            ST_IDLE: begin
                if (bus_if.run || bus_if.step) begin
                    state_d  = ST_P1;
                    cnt_load = 1'b1;
                end
            end
            ST_P1: begin
                if (cnt_zero) begin
                    state_d      = ST_D1;
                    cnt_load     = 1'b1;
                    cnt_load_val = dead_m1;
                end
            end
            ST_D1: begin
                if (cnt_zero) begin
                    state_d  = ST_P2;
                    cnt_load = 1'b1;
                end
            end
            ST_P2: begin
                if (cnt_zero) begin
                    state_d      = ST_D2;
                    cnt_load     = 1'b1;
                    cnt_load_val = dead_m1;
                end
            end
            ST_D2: begin
                if (cnt_zero) begin
                    if (bus_if.run) begin
                        state_d  = ST_P1;
                        cnt_load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ph1_d             = (state_d == ST_P1);
        ph2_d             = (state_d == ST_P2);
        bus_if.busy       = (state_q != ST_IDLE);
        bus_if.cycle_done = (state_q == ST_D2) && cnt_zero;
    end

    // Phase enables come straight from flops so they cannot glitch on state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph1_q <= 1'b0;
            ph2_q <= 1'b0;
        end else begin
            ph1_q <= ph1_d;
            ph2_q <= ph2_d;
        end
    end

    assign bus_if.ph1  = ph1_q;
    assign bus_if.nph1 = ~ph1_q;
    assign bus_if.ph2  = ph2_q;
    assign bus_if.nph2 = ~ph2_q;

endmodule

// File: tb/tb_nonoverlap_phase_gen.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor
// compares them against the generator at each falling clock edge.
module tb_nonoverlap_phase_gen;

    localparam int CNT_W = 4;

    typedef struct {
        int         cyc;
        bit         is_async;
        logic [5:0] vec;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    event chk_now;

    nonoverlap_phase_gen_if #(.CNT_W(CNT_W)) dut_if ();

    nonoverlap_phase_gen #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [5:0] out_vec(input bit p1, input bit p2, input bit b, input bit cd);
        return {p1, ~p1, p2, ~p2, b, cd};
    endfunction

    task automatic push(input int off, input bit p1, input bit p2, input bit b, input bit cd,
                        input string name);
        exp_t e;
        e.cyc      = cyc + off;
        e.is_async = 1'b0;
        e.vec      = out_vec(p1, p2, b, cd);
        e.name     = name;
        exp_q.push_back(e);
    endtask

    // One full P1/D1/P2/D2 cycle starting at offset off; zero widths count as 1.
    task automatic push_period(input int off, input int h1, input int h2, input int d,
                               input string name);
        int o;
        int e1;
        int e2;
        int ed;
        o  = off;
        e1 = (h1 == 0) ? 1 : h1;
        e2 = (h2 == 0) ? 1 : h2;
        ed = (d == 0) ? 1 : d;
        for (int i = 0; i < e1; i++) push(o++, 1, 0, 1, 0, {name, "_p1"});
        for (int i = 0; i < ed; i++) push(o++, 0, 0, 1, 0, {name, "_d1"});
        for (int i = 0; i < e2; i++) push(o++, 0, 1, 1, 0, {name, "_p2"});
        for (int i = 0; i < ed; i++) push(o++, 0, 0, 1, (i == ed - 1), {name, "_d2"});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit run, input bit step, input int hi, input int dead);
        dut_if.run      = run;
        dut_if.step     = step;
        dut_if.high_cyc = CNT_W'(hi);
        dut_if.dead_cyc = CNT_W'(dead);
    endtask

    task automatic run_periods(input int hi, input int dead, input int n, input string name);
        int per;
        per = 2 * (((hi == 0) ? 1 : hi) + ((dead == 0) ? 1 : dead));
        for (int k = 0; k < n; k++) push_period(1 + k * per, hi, hi, dead, name);
        push(n * per + 1, 0, 0, 0, 0, {name, "_idle"});
        push(n * per + 2, 0, 0, 0, 0, {name, "_idle"});
        drive(1, 0, hi, dead);
        tick(n * per);
        dut_if.run = 1'b0;
        tick(2);
    endtask

    task automatic compare(input exp_t e);
        logic [5:0] act;
        act = {dut_if.ph1, dut_if.nph1, dut_if.ph2, dut_if.nph2, dut_if.busy, dut_if.cycle_done};
        n_tests++;
        if (act !== e.vec) begin
            n_fail++;
            $display("FAIL %s cyc=%0d {ph1,nph1,ph2,nph2,busy,done} got=%b want=%b",
                     e.name, e.cyc, act, e.vec);
        end
    endtask

    // Monitor: the only process that counts comparisons.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (exp_q.size() != 0 && exp_q[0].is_async) begin
                e = exp_q.pop_front();
                compare(e);
            end else begin
                n_tests++;
                if (dut_if.ph1 === 1'b1 && dut_if.ph2 === 1'b1) begin
                    n_fail++;
                    $display("FAIL overlap cyc=%0d ph1=%b ph2=%b want not both 1",
                             cyc, dut_if.ph1, dut_if.ph2);
                end
                while (exp_q.size() != 0 && !exp_q[0].is_async && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    if (e.cyc < cyc) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, cyc);
                    end else begin
                        compare(e);
                    end
                end
            end
        end
    end

    initial begin
        exp_t ea;

        // 1: reset held with random inputs
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) push(i, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            tick(1);
        end
        drive(0, 0, 3, 1);
        rst = 1'b0;
        push(1, 0, 0, 0, 0, "idle_after_reset");
        push(2, 0, 0, 0, 0, "idle_after_reset");
        tick(2);

        // 2: 3/1 free-run, period 8
        run_periods(3, 1, 2, "h3d1");

        // 3: 0/0 behaves as 1/1, period 4
        run_periods(0, 0, 2, "h0d0");

        // 4: RUN dropped in second cycle of P2, cycle finishes
        push_period(1, 3, 3, 2, "rundrop");
        push(11, 0, 0, 0, 0, "rundrop_idle");
        push(12, 0, 0, 0, 0, "rundrop_idle");
        drive(1, 0, 3, 2);
        tick(7);
        dut_if.run = 1'b0;
        tick(5);

        // 5: single STEP, second STEP during P2 ignored
        push_period(1, 2, 2, 1, "step");
        push(7, 0, 0, 0, 0, "step_idle");
        push(8, 0, 0, 0, 0, "step_idle");
        drive(0, 1, 2, 1);
        tick(1);
        dut_if.step = 1'b0;
        tick(3);
        dut_if.step = 1'b1;
        tick(1);
        dut_if.step = 1'b0;
        tick(4);

        // 6: async reset mid-P1, restart on first edge after release
        push(1, 1, 0, 1, 0, "pre_rst_p1");
        drive(1, 0, 4, 1);
        tick(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        ea.cyc      = cyc;
        ea.is_async = 1'b1;
        ea.vec      = out_vec(0, 0, 0, 0);
        ea.name     = "async_rst";
        exp_q.push_back(ea);
        ->chk_now;
        push(1, 0, 0, 0, 0, "rst_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_period(1, 4, 4, 1, "post_rst");
        tick(10);
        dut_if.run = 1'b0;
        push(1, 0, 0, 0, 0, "post_rst_idle");
        tick(2);

        // 7: HIGH_CYC 4->2 mid-P1: P1 stays 4, P2 becomes 2
        push_period(1, 4, 2, 1, "hchg");
        push(9, 0, 0, 0, 0, "hchg_idle");
        drive(1, 0, 4, 1);
        tick(2);
        dut_if.high_cyc = CNT_W'(2);
        dut_if.run      = 1'b0;
        tick(8);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
